// File: rtl/mc_cpu_pkg.sv
// Shared encodings and enums for the multi-cycle MIPS-subset core.
package mc_cpu_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [5:0] OP_RFMT = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

endpackage

// File: rtl/mc_cpu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, R0 hardwired to zero.
module mc_regfile
  import mc_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned IDX_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  raddr_a_i,
  input  logic [IDX_W-1:0]  raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o_c,
  output logic [DATA_W-1:0] rdata_b_o_c,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // Writes to index 0 are dropped so R0 keeps its reset value of zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o_c = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o_c = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-subset core: one FSM drives fetch/decode/execute/memory/writeback
// over a single req/ready memory port.
module mc_cpu
  import mc_cpu_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       NREGS    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              trap
);

  localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [DATA_W-1:0]   aluout_q, aluout_d, mdr_q, mdr_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic                retire_q, retire_d, trap_q, trap_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [5:0]          opcode_c, funct_c;
  logic [IDX_W-1:0]    rs_c, rt_c, rd_c;
  logic [DATA_W-1:0]   rdata_a_c, rdata_b_c;
  alu_op_e             alu_op_c;
  logic                legal_c, xfer_done_c, taken_c;
  logic [DATA_W-1:0]   alu_b_c, alu_c;
  logic [ADDR_W-1:0]   pc_plus4_c, br_target_c, data_addr_c;
  logic                rf_we_c;
  logic [IDX_W-1:0]    rf_waddr_c;
  logic [DATA_W-1:0]   rf_wdata_c;
  logic                unused_c;

  assign opcode_c = ir_q[31:26];
  assign funct_c  = ir_q[5:0];
  assign rs_c     = IDX_W'(ir_q[25:21]);
  assign rt_c     = IDX_W'(ir_q[20:16]);
  assign rd_c     = IDX_W'(ir_q[15:11]);
  assign unused_c = ^ir_q[25:6];

  // Legality and ALU operation from opcode/funct.
  always_comb begin
    alu_op_c = ALU_ADD;
    legal_c  = 1'b1;
    case (opcode_c)
      OP_RFMT: begin
        case (funct_c)
          FN_ADD:  alu_op_c = ALU_ADD;
          FN_SUB:  alu_op_c = ALU_SUB;
          FN_AND:  alu_op_c = ALU_AND;
          FN_OR:   alu_op_c = ALU_OR;
          FN_SLT:  alu_op_c = ALU_SLT;
          default: legal_c  = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: alu_op_c = ALU_ADD;
      default: legal_c = 1'b0;
    endcase
  end

  assign alu_b_c = (opcode_c == OP_RFMT) ? b_q : imm_q;

  always_comb begin
    case (alu_op_c)
      ALU_SUB: alu_c = a_q - alu_b_c;
      ALU_AND: alu_c = a_q & alu_b_c;
      ALU_OR:  alu_c = a_q | alu_b_c;
      ALU_SLT: alu_c = ($signed(a_q) < $signed(alu_b_c)) ? DATA_W'(1) : '0;
      default: alu_c = a_q + alu_b_c;
    endcase
  end

  assign taken_c     = (opcode_c == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
  assign pc_plus4_c  = pc_q + ADDR_W'(4);
  assign br_target_c = pc_plus4_c + (ADDR_W'($signed(imm_q)) << 2);
  assign data_addr_c = ADDR_W'(alu_c) & ~ADDR_W'(3);
  assign xfer_done_c = mem_req_q && mem_ready;

  assign rf_we_c    = (state_q == S_WB);
  assign rf_waddr_c = (opcode_c == OP_RFMT) ? rd_c : rt_c;
  assign rf_wdata_c = (opcode_c == OP_LW) ? mdr_q : aluout_q;

  mc_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .IDX_W  (IDX_W)
  ) u_regfile (
    .clock       (clock),
    .reset       (reset),
    .raddr_a_i   (rs_c),
    .raddr_b_i   (rt_c),
    .rdata_a_o_c (rdata_a_c),
    .rdata_b_o_c (rdata_b_c),
    .we_i        (rf_we_c),
    .waddr_i     (rf_waddr_c),
    .wdata_i     (rf_wdata_c)
  );

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    aluout_d    = aluout_q;
    mdr_d       = mdr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    retire_d    = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (xfer_done_c) begin
          ir_d    = INSTR_W'(mem_rdata);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rdata_a_c;
        b_d     = rdata_b_c;
        imm_d   = DATA_W'($signed(ir_q[15:0]));
        state_d = legal_c ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        aluout_d = alu_c;
        case (opcode_c)
          OP_BEQ, OP_BNE: begin
            pc_d     = taken_c ? br_target_c : pc_plus4_c;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
          OP_LW, OP_SW: state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (xfer_done_c) begin
          if (opcode_c == OP_LW) begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end else begin
            pc_d     = pc_plus4_c;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_WB: begin
        pc_d     = pc_plus4_c;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase

    // Port outputs are derived from the next state so they are valid on state entry
    // and stay constant while a transfer waits.
    mem_req_d = (state_d == S_FETCH) || (state_d == S_MEM);
    mem_we_d  = (state_d == S_MEM) && (opcode_c == OP_SW);
    trap_d    = (state_d == S_TRAP);
    if (state_d == S_FETCH) begin
      mem_addr_d = pc_d;
    end else if ((state_d == S_MEM) && (state_q == S_EXEC)) begin
      mem_addr_d = data_addr_c;
      if (opcode_c == OP_SW) mem_wdata_d = b_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      aluout_q    <= '0;
      mdr_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      retire_q    <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      aluout_q    <= aluout_d;
      mdr_q       <= mdr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      retire_q    <= retire_d;
      trap_q      <= trap_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc_out    = pc_q;
  assign retire    = retire_q;
  assign trap      = trap_q;

endmodule

// File: tb/tb_mc_cpu.sv
// Directed bench for mc_cpu: small programs in a wait-state memory model, checked
// through memory traffic, retire timing, PC and trap.
module tb_mc_cpu;

  logic        clock, reset;
  logic        mem_req, mem_we, mem_ready, retire, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;

  mc_cpu #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .NREGS    (32),
    .RESET_PC (32'h0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc_out    (pc_out),
    .retire    (retire),
    .trap      (trap)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          t0 = 0;
  logic [31:0] mem [64];
  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  int          slow_waits = 0;
  logic [32:0] xfer_q [$];
  logic [63:0] wr_q [$];
  int          ret_q [$];

  logic [32:0] exp_x2 [9] = '{33'h0_0000_0000, 33'h0_0000_0004, 33'h0_0000_0014,
                              33'h1_0000_0008, 33'h0_0000_0018, 33'h0_0000_0008,
                              33'h0_0000_001C, 33'h1_0000_0040, 33'h0_0000_0020};
  int          exp_r2 [5] = '{4, 7, 14, 22, 26};
  logic [31:0] exp_f3 [9] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h20,
                              32'h2C, 32'h10, 32'h10, 32'h10};
  logic [63:0] exp_w1 [5] = '{{32'h80, 32'h2}, {32'h84, 32'h1}, {32'h88, 32'h8},
                              {32'h8C, 32'h5}, {32'h90, 32'hFFFF_FFFD}};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: slow_waits ready-low cycles on transfers to slow_addr, else zero-wait.
  initial begin
    int           wcnt;
    bit           done;
    logic [64:0]  snap;
    wcnt = 0; done = 0; snap = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (done) wcnt = 0;
      done      = 0;
      mem_ready = 1'b0;
      if (mem_req) begin
        if ((mem_addr == slow_addr) && (wcnt < slow_waits)) begin
          if (wcnt == 0) snap = {mem_we, mem_addr, mem_wdata};
          else check_eq("req_stable", 128'({mem_we, mem_addr, mem_wdata}), 128'(snap));
          wcnt++;
        end else begin
          mem_ready = 1'b1;
          done      = 1;
          mem_rdata = mem[mem_addr[7:2]];
          xfer_q.push_back({mem_we, mem_addr});
          if (mem_we) begin
            mem[mem_addr[7:2]] = mem_wdata;
            wr_q.push_back({mem_addr, mem_wdata});
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    if (reset && retire) ret_q.push_back(cyc - t0);
  end

  task automatic put(input int unsigned addr, input logic [31:0] w);
    mem[addr >> 2] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic release_reset();
    bit seen;
    seen = 0;
    xfer_q.delete();
    wr_q.delete();
    ret_q.delete();
    reset = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = mem_req;
    end
    t0 = cyc;
    check_eq("first_fetch", 128'({seen, mem_we, mem_addr}), 128'({1'b1, 1'b0, 32'h0}));
  endtask

  task automatic wait_trap(input string tag);
    for (int i = 0; i < 400 && !trap; i++) @(negedge clock);
    check_eq(tag, 128'(trap), 128'(1));
  endtask

  task automatic check_ret(input int idx, input int exp);
    int got;
    got = (idx < ret_q.size()) ? ret_q[idx] : -1;
    check_eq($sformatf("retire_%0d", idx), 128'(got), 128'(exp));
  endtask

  task automatic check_wr(input int idx, input logic [63:0] exp);
    logic [63:0] got;
    got = (idx < wr_q.size()) ? wr_q[idx] : 64'hDEAD_DEAD_DEAD_DEAD;
    check_eq($sformatf("write_%0d", idx), 128'(got), 128'(exp));
  endtask

  task automatic check_xfer(input int idx, input logic [32:0] exp);
    logic [32:0] got;
    got = (idx < xfer_q.size()) ? xfer_q[idx] : 33'h1_DEAD_DEAD;
    check_eq($sformatf("xfer_%0d", idx), 128'(got), 128'(exp));
  endtask

  initial begin
    int highs;
    bit seen;

    // Reset state: all outputs zero while reset is held.
    clear_mem();
    put('h00, 32'h2001_0005); // addi r1,r0,5
    put('h04, 32'h2002_FFFD); // addi r2,r0,-3
    put('h08, 32'h0022_1820); // add  r3,r1,r2
    put('h0C, 32'h0041_202A); // slt  r4,r2,r1
    put('h10, 32'h0022_3022); // sub  r6,r1,r2
    put('h14, 32'h0022_3824); // and  r7,r1,r2
    put('h18, 32'h0022_4025); // or   r8,r1,r2
    put('h1C, 32'hAC03_0080); // sw r3,0x80
    put('h20, 32'hAC04_0084); // sw r4,0x84
    put('h24, 32'hAC06_0088); // sw r6,0x88
    put('h28, 32'hAC07_008C); // sw r7,0x8c
    put('h2C, 32'hAC08_0090); // sw r8,0x90
    put('h30, 32'hFC00_0000); // opcode 0x3f
    hold_reset();
    check_eq("reset_outputs", 128'({mem_req, mem_we, mem_addr, mem_wdata, pc_out, retire, trap}), 128'(0));

    // ALU ops at zero wait: one retire every 4 cycles, then illegal opcode traps.
    release_reset();
    wait_trap("trap_opcode");
    for (int i = 0; i < 12; i++) check_ret(i, 4 * i + 4);
    for (int i = 0; i < 5; i++) check_wr(i, exp_w1[i]);
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (mem_req || !trap) highs++;
    end
    check_eq("trap_absorbing", 128'(highs), 128'(0));
    check_eq("trap_pc", 128'(pc_out), 128'(32'h30));

    // SW/LW to 0x8 with 3 wait states on each data transfer.
    hold_reset();
    check_eq("trap_cleared", 128'({trap, mem_req}), 128'(0));
    clear_mem();
    put('h00, 32'h2003_0002); // addi r3,r0,2
    put('h04, 32'h1000_0003); // beq r0,r0,+3 -> 0x14
    put('h14, 32'hAC03_0008); // sw r3,8(r0)
    put('h18, 32'h8C05_0008); // lw r5,8(r0)
    put('h1C, 32'hAC05_0040); // sw r5,0x40(r0)
    put('h20, 32'hFC00_0000);
    slow_addr  = 32'h8;
    slow_waits = 3;
    release_reset();
    wait_trap("trap_p2");
    for (int i = 0; i < 9; i++) check_xfer(i, exp_x2[i]);
    for (int i = 0; i < 5; i++) check_ret(i, exp_r2[i]);
    check_wr(0, {32'h8, 32'h2});
    check_wr(1, {32'h40, 32'h2});

    // Branches: not-taken BEQ/BNE, taken BEQ to 0x2C, BNE loop at 0x10.
    hold_reset();
    clear_mem();
    slow_waits = 0;
    put('h00, 32'h2001_0005); // addi r1,r0,5
    put('h04, 32'h1020_0001); // beq r1,r0,+1 (not taken)
    put('h08, 32'h1421_0005); // bne r1,r1,+5 (not taken)
    put('h0C, 32'h1000_0004); // beq r0,r0,+4 -> 0x20
    put('h20, 32'h1021_0002); // beq r1,r1,+2 -> 0x2C
    put('h2C, 32'h1420_FFF8); // bne r1,r0,-8 -> 0x10
    put('h10, 32'h1420_FFFF); // bne r1,r0,-1 -> 0x10
    release_reset();
    for (int i = 0; i < 200 && xfer_q.size() < 9; i++) @(negedge clock);
    for (int i = 0; i < 9; i++) check_xfer(i, {1'b0, exp_f3[i]});
    check_ret(1, 7);

    // Reset in the middle of an SW wait abandons the store.
    hold_reset();
    clear_mem();
    put('h00, 32'h2001_0005); // addi r1,r0,5
    put('h04, 32'hAC01_0008); // sw r1,8(r0)
    slow_addr  = 32'h8;
    slow_waits = 100;
    release_reset();
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clock);
      seen = mem_req && mem_we;
    end
    check_eq("sw_wait_seen", 128'({seen, mem_addr, mem_wdata}), 128'({1'b1, 32'h8, 32'h5}));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_eq("reset_mid_mem", 128'({mem_req, mem_we, mem_addr, mem_wdata, pc_out, retire, trap}), 128'(0));
    check_eq("no_store", 128'(wr_q.size()), 128'(0));

    // Restart: R0 ignores writes, R1 was cleared, illegal funct traps.
    clear_mem();
    slow_waits = 0;
    put('h00, 32'h2000_0007); // addi r0,r0,7
    put('h04, 32'hAC00_0044); // sw r0,0x44(r0)
    put('h08, 32'hAC01_0048); // sw r1,0x48(r0)
    put('h0C, 32'h0000_0021); // funct 0x21
    hold_reset();
    release_reset();
    wait_trap("trap_funct");
    check_wr(0, {32'h44, 32'h0});
    check_wr(1, {32'h48, 32'h0});
    check_eq("trap_funct_pc", 128'(pc_out), 128'(32'hC));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
